feature_quantizer_packer: RTL

// Front end of the sparse classifier: accepts raw IIoT feature words one per beat, quantizes each to a
// 2-bit code against three programmable thresholds, and packs a full frame of codes into the flat

---
 rtl/feature_quantizer_packer_if.sv | 29 ++
 rtl/feature_quantizer_packer.sv | 114 +++++++++++
 2 files changed

// File: rtl/feature_quantizer_packer_if.sv
// rtl/feature_quantizer_packer_if.sv - feature stream, packed frame and threshold config bundle
// Groups the beat input, packed frame output, threshold writes and frame error pulse.
interface feature_quantizer_packer_if #(
   parameter int NUM_FEATURES = 12,
   parameter int IN_WIDTH     = 16,
   parameter int CFG_AW       = 6
);
   logic                      s_valid;
   logic                      s_ready;
   logic [IN_WIDTH-1:0]       s_data;
   logic                      s_last;
   logic                      m_valid;
   logic                      m_ready;
   logic [2*NUM_FEATURES-1:0] m_data;
   logic                      cfg_we;
   logic [CFG_AW-1:0]         cfg_addr;
   logic [IN_WIDTH-1:0]       cfg_data;
   logic                      frame_err;

   modport slave (
      input  s_valid, s_data, s_last, m_ready, cfg_we, cfg_addr, cfg_data,
      output s_ready, m_valid, m_data, frame_err
   );

   modport master (
      output s_valid, s_data, s_last, m_ready, cfg_we, cfg_addr, cfg_data,
      input  s_ready, m_valid, m_data, frame_err
   );
endinterface

// File: rtl/feature_quantizer_packer.sv
// rtl/feature_quantizer_packer.sv - quantizes raw features to 2-bit codes and packs a frame
// Each beat is compared against three thresholds of its slot; a full frame is held for one consumer.
module feature_quantizer_packer #(
   parameter int NUM_FEATURES = 12,
   parameter int IN_WIDTH     = 16,
   parameter int CFG_AW       = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   feature_quantizer_packer_if.slave bus
);
   localparam int NUM_THR = 3 * NUM_FEATURES;
   localparam int IDX_W   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
   localparam int OUT_W   = 2 * NUM_FEATURES;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [OUT_W-1:0]    shadow_q, shadow_d;
   logic [OUT_W-1:0]    m_data_q, m_data_d;
   logic                frame_err_q, frame_err_d;
   logic [IN_WIDTH-1:0] thr_q [NUM_THR];

   logic [CFG_AW-1:0]   thr_base;
   logic [1:0]          code;
   logic                last_slot;
   logic                cfg_in_range;

   assign thr_base     = CFG_AW'(idx_q) * CFG_AW'(3);
   assign last_slot    = (idx_q == IDX_W'(NUM_FEATURES - 1));
   assign cfg_in_range = ({1'b0, bus.cfg_addr} < (CFG_AW + 1)'(NUM_THR));

   // A count of crossed thresholds, so non-monotonic thresholds still yield 0..3.
   always_comb begin
      code = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (bus.s_data >= thr_q[thr_base + CFG_AW'(k)]) begin
            code = code + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_THR; t++) begin
            thr_q[t] <= '0;
         end
      end else if (bus.cfg_we && cfg_in_range) begin
         thr_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      m_data_d    = m_data_q;
      frame_err_d = 1'b0;
      case (state_q)
         COLLECT: begin
            if (bus.s_valid) begin
               for (int f = 0; f < NUM_FEATURES; f++) begin
                  if (idx_q == IDX_W'(f)) begin
                     shadow_d[2*f +: 2] = code;
                  end
               end
               if (last_slot && bus.s_last) begin
                  m_data_d = shadow_d;
                  idx_d    = '0;
                  state_d  = HOLD;
               end else if (last_slot || bus.s_last) begin
                  // Length mismatch: the beat is consumed and the partial frame dropped.
                  frame_err_d = 1'b1;
                  shadow_d    = '0;
                  idx_d       = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         HOLD: begin
            if (bus.m_ready) begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         shadow_q    <= '0;
         m_data_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         m_data_q    <= m_data_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.s_ready   = (state_q == COLLECT);
   assign bus.m_valid   = (state_q == HOLD);
   assign bus.m_data    = m_data_q;
   assign bus.frame_err = frame_err_q;
endmodule
